// File: rtl/oam_dma_controller.sv
// -----------------------------------------------------------------------------
// oam_dma_controller
//   Bus master sitting between the cpu and the system bus. While idle, cpu bus
//   cycles pass straight through. A cpu write to DMA_REG_ADDR copies
//   TRANSFER_LENGTH bytes from page {P,8'h00} to OAM_DATA_ADDR. During the
//   copy the cpu is halted and the controller owns the bus. Every register
//   advances only on cycle_tick_i.
//
// Ports
//   clock_i, reset_i            clock, asynchronous active-high reset
//   cycle_tick_i                one-clock strobe per cpu bus cycle
//   cpu_address_i/_valid_i      cpu address and address valid
//   cpu_data_i/_valid_i         cpu write data and write strobe
//   cpu_data_o/_valid_o         read data and read valid returned to the cpu
//   cpu_halt_o                  stalls the cpu while high (registered)
//   bus_address_o/_valid_o      system bus address and address valid
//   bus_data_o/_valid_o         system bus write data and write strobe
//   bus_data_i/_valid_i         system bus read data and read valid
//   dma_busy_o                  high from the start tick through the last write
// -----------------------------------------------------------------------------
module oam_dma_controller #(
    parameter logic [15:0] DMA_REG_ADDR    = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR   = 16'h2004,
    parameter int unsigned TRANSFER_LENGTH = 256
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        cycle_tick_i,
    input  logic [15:0] cpu_address_i,
    input  logic        cpu_address_valid_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_data_valid_i,
    output logic [7:0]  cpu_data_o,
    output logic        cpu_data_valid_o,
    output logic        cpu_halt_o,
    output logic [15:0] bus_address_o,
    output logic        bus_address_valid_o,
    output logic [7:0]  bus_data_o,
    output logic        bus_data_valid_o,
    input  logic [7:0]  bus_data_i,
    input  logic        bus_data_valid_i,
    output logic        dma_busy_o
);

    localparam int unsigned IDX_W = 9;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRANSFER_LENGTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       page_q, page_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [7:0]       byte_q, byte_d;
    logic             parity_q, parity_d;
    logic             cpu_halt_q, cpu_halt_d;
    logic             dma_busy_q, dma_busy_d;
    logic             start_c;

    assign start_c = cpu_address_valid_i & cpu_data_valid_i &
                     (cpu_address_i == DMA_REG_ADDR);

    assign cpu_halt_o = cpu_halt_q;
    assign dma_busy_o = dma_busy_q;

    // State and datapath registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            page_q     <= '0;
            index_q    <= '0;
            byte_q     <= '0;
            parity_q   <= 1'b0;
            cpu_halt_q <= 1'b0;
            dma_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            index_q    <= index_d;
            byte_q     <= byte_d;
            parity_q   <= parity_d;
            cpu_halt_q <= cpu_halt_d;
            dma_busy_q <= dma_busy_d;
        end
    end

    // Next-state and bus/cpu output decode
    always_comb begin
        state_d             = state_q;
        page_d              = page_q;
        index_d             = index_q;
        byte_d              = byte_q;
        parity_d            = parity_q ^ cycle_tick_i;
        cpu_halt_d          = cpu_halt_q;
        dma_busy_d          = dma_busy_q;
        cpu_data_o          = 8'h00;
        cpu_data_valid_o    = 1'b0;
        bus_address_o       = 16'h0000;
        bus_address_valid_o = 1'b0;
        bus_data_o          = 8'h00;
        bus_data_valid_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bus_address_o       = cpu_address_i;
                bus_address_valid_o = cpu_address_valid_i;
                bus_data_o          = cpu_data_i;
                bus_data_valid_o    = cpu_data_valid_i;
                cpu_data_o          = bus_data_i;
                cpu_data_valid_o    = bus_data_valid_i;
                if (cycle_tick_i && start_c) begin
                    page_d     = cpu_data_i;
                    index_d    = '0;
                    state_d    = ST_HALT;
                    cpu_halt_d = 1'b1;
                    dma_busy_d = 1'b1;
                end
            end
            ST_HALT: begin
                // HALT is the tick after the start tick, so an odd HALT tick
                // means an even start and READ already lands on an even tick.
                if (cycle_tick_i) begin
                    state_d = parity_q ? ST_READ : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (cycle_tick_i) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                bus_address_o       = {page_q, index_q[7:0]};
                bus_address_valid_o = 1'b1;
                // No read data yet: hold the address for another tick.
                if (cycle_tick_i && bus_data_valid_i) begin
                    byte_d  = bus_data_i;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                bus_address_o       = OAM_DATA_ADDR;
                bus_address_valid_o = 1'b1;
                bus_data_o          = byte_q;
                bus_data_valid_o    = 1'b1;
                if (cycle_tick_i) begin
                    if (index_q == LAST_IDX) begin
                        state_d    = ST_IDLE;
                        cpu_halt_d = 1'b0;
                        dma_busy_d = 1'b0;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                        state_d = ST_READ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
